// File: rtl/mxint8_block_collector_pkg.sv
// Shared constants and bank state encoding for the MXINT8 block collector.
// Optional double buffering: define MXINT8_COLLECTOR_DBUF_EN.
package mxint8_block_collector_pkg;

  localparam int MX_BLOCK_SIZE  = 32;
  localparam int MX_ELEM_WIDTH  = 8;
  localparam int MX_SCALE_WIDTH = 8;

  localparam logic [7:0] MX_SCALE_NAN = 8'hFF;

  typedef enum logic [1:0] {
    BANK_EMPTY = 2'd0,
    BANK_FILL  = 2'd1,
    BANK_FULL  = 2'd2
  } bank_state_e;

endpackage

// File: rtl/mxint8_block_collector_bank.sv
// One element/scale register bank with its write index and
// EMPTY/FILL/FULL state; the top instantiates one or two of these.
module mxint8_block_collector_bank
  import mxint8_block_collector_pkg::*;
#(
  parameter int BLOCK_SIZE  = MX_BLOCK_SIZE,
  parameter int ELEM_WIDTH  = MX_ELEM_WIDTH,
  parameter int SCALE_WIDTH = MX_SCALE_WIDTH,
  parameter int CW          = $clog2(BLOCK_SIZE + 1)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_wr,
  input  logic [ELEM_WIDTH-1:0]                i_elem,
  input  logic [SCALE_WIDTH-1:0]               i_scale,
  input  logic                                 i_flush,
  input  logic                                 i_rd,
  output logic                                 o_full,
  output logic [CW-1:0]                        o_count,
  output logic [SCALE_WIDTH-1:0]               o_scale,
  output logic [BLOCK_SIZE-1:0][ELEM_WIDTH-1:0] o_elems
);

  localparam int IW = $clog2(BLOCK_SIZE);

  bank_state_e                          r_state;
  logic [CW-1:0]                        r_count;
  logic [SCALE_WIDTH-1:0]               r_scale;
  logic [BLOCK_SIZE-1:0][ELEM_WIDTH-1:0] r_elems;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= BANK_EMPTY;
      r_count <= '0;
      r_scale <= '0;
      r_elems <= '0;
    end else begin
      unique case (r_state)
        BANK_EMPTY, BANK_FILL: begin
          // Flush never coincides with a write: the top drops ready.
          if (i_flush) begin
            r_count <= '0;
            r_state <= BANK_EMPTY;
          end else if (i_wr) begin
            r_elems[r_count[IW-1:0]] <= i_elem;
            if (r_count == '0)
              r_scale <= i_scale;
            if (r_count == CW'(BLOCK_SIZE - 1)) begin
              r_count <= '0;
              r_state <= BANK_FULL;
            end else begin
              r_count <= r_count + CW'(1);
              r_state <= BANK_FILL;
            end
          end
        end
        BANK_FULL: begin
          if (i_rd)
            r_state <= BANK_EMPTY;
        end
        default: r_state <= BANK_EMPTY;
      endcase
    end
  end

  assign o_full  = (r_state == BANK_FULL);
  assign o_count = r_count;
  assign o_scale = r_scale;
  assign o_elems = r_elems;

endmodule

// File: rtl/mxint8_block_collector.sv
// Serial-to-parallel MXINT8 block collector feeding mxint8_sum.
// Define MXINT8_COLLECTOR_DBUF_EN for ping/pong banks (1 elem/cycle).
module mxint8_block_collector
  import mxint8_block_collector_pkg::*;
#(
  parameter int BLOCK_SIZE  = MX_BLOCK_SIZE,
  parameter int ELEM_WIDTH  = MX_ELEM_WIDTH,
  parameter int SCALE_WIDTH = MX_SCALE_WIDTH
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_elem_valid,
  output logic                                  o_elem_ready,
  input  logic [ELEM_WIDTH-1:0]                 i_elem,
  input  logic [SCALE_WIDTH-1:0]                i_scale,
  input  logic                                  i_flush,
  output logic                                  o_blk_valid,
  input  logic                                  i_blk_ready,
  output logic [SCALE_WIDTH-1:0]                o_scale,
  output logic [BLOCK_SIZE-1:0][ELEM_WIDTH-1:0] o_elements,
  output logic                                  o_scale_nan,
  output logic [$clog2(BLOCK_SIZE+1)-1:0]       o_fill_count
);

  localparam int CW = $clog2(BLOCK_SIZE + 1);

`ifdef MXINT8_COLLECTOR_DBUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic r_rdy_en;
  logic r_wptr;
  logic r_rptr;

  logic                                  w_full  [NB];
  logic [CW-1:0]                         w_count [NB];
  logic [SCALE_WIDTH-1:0]                w_scale [NB];
  logic [BLOCK_SIZE-1:0][ELEM_WIDTH-1:0] w_elems [NB];

  logic w_beat;
  logic w_last;
  logic w_take;

  // Write bank being full means every bank is full.
  assign o_elem_ready = r_rdy_en && !i_flush && !w_full[r_wptr];
  assign w_beat       = i_elem_valid && o_elem_ready;
  assign w_last       = w_beat &&
                        (w_count[r_wptr] == CW'(BLOCK_SIZE - 1));
  assign o_blk_valid  = w_full[r_rptr];
  assign w_take       = o_blk_valid && i_blk_ready;

  for (genvar g = 0; g < NB; g++) begin : g_bank
    mxint8_block_collector_bank #(
      .BLOCK_SIZE  (BLOCK_SIZE),
      .ELEM_WIDTH  (ELEM_WIDTH),
      .SCALE_WIDTH (SCALE_WIDTH),
      .CW          (CW)
    ) u_bank (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_wr    (w_beat && (r_wptr == 1'(g))),
      .i_elem  (i_elem),
      .i_scale (i_scale),
      .i_flush (i_flush && (r_wptr == 1'(g))),
      .i_rd    (w_take && (r_rptr == 1'(g))),
      .o_full  (w_full[g]),
      .o_count (w_count[g]),
      .o_scale (w_scale[g]),
      .o_elems (w_elems[g])
    );
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdy_en <= 1'b0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
`ifdef MXINT8_COLLECTOR_DBUF_EN
      if (w_last)
        r_wptr <= ~r_wptr;
      if (w_take)
        r_rptr <= ~r_rptr;
`else
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
`endif
    end
  end

  assign o_scale      = w_scale[r_rptr];
  assign o_elements   = w_elems[r_rptr];
  assign o_fill_count = w_count[r_wptr];
  assign o_scale_nan  = o_blk_valid &&
                        (o_scale == SCALE_WIDTH'(MX_SCALE_NAN));

  logic w_unused;
  assign w_unused = w_last;

endmodule

// File: tb/tb_mxint8_block_collector.sv
// Self-checking bench for mxint8_block_collector against a queue model.
// Works with and without MXINT8_COLLECTOR_DBUF_EN.
module tb_mxint8_block_collector;

  localparam int BS = 32;
  localparam int EW = 8;
  localparam int SW = 8;
  localparam int CW = 6;
`ifdef MXINT8_COLLECTOR_DBUF_EN
  localparam int CAP     = 2;
  localparam int SPACING = 32;
`else
  localparam int CAP     = 1;
  localparam int SPACING = 33;
`endif

  typedef logic [BS-1:0][EW-1:0] arr_t;
  typedef struct {
    logic [SW-1:0] sc;
    arr_t          el;
  } blk_t;

  logic          clk;
  logic          rst;
  logic          elem_valid;
  logic          elem_ready;
  logic [EW-1:0] elem;
  logic [SW-1:0] scale;
  logic          flush;
  logic          blk_valid;
  logic          blk_ready;
  logic [SW-1:0] o_scale;
  arr_t          elements;
  logic          scale_nan;
  logic [CW-1:0] fill_count;

  mxint8_block_collector dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_elem_valid (elem_valid),
    .o_elem_ready (elem_ready),
    .i_elem       (elem),
    .i_scale      (scale),
    .i_flush      (flush),
    .o_blk_valid  (blk_valid),
    .i_blk_ready  (blk_ready),
    .o_scale      (o_scale),
    .o_elements   (elements),
    .o_scale_nan  (scale_nan),
    .o_fill_count (fill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs;
  int checks;

  // Behavioural model: beats collected into a list, finished blocks queued.
  bit            m_en;
  logic [EW-1:0] m_fill[$];
  logic [SW-1:0] m_sc;
  blk_t          m_pend[$];

  function automatic bit exp_ready();
    return m_en && !flush && (m_pend.size() < CAP);
  endfunction

  task automatic model_clear();
    m_fill.delete();
    m_pend.delete();
    m_en = 1'b0;
  endtask

  task automatic step(input logic v, input logic [EW-1:0] e,
                      input logic [SW-1:0] s, input logic f,
                      input logic br);
    bit   rdy;
    bit   hs;
    blk_t nb;
    elem_valid = v;
    elem       = e;
    scale      = s;
    flush      = f;
    blk_ready  = br;
    rdy = m_en && !f && (m_pend.size() < CAP);
    hs  = (m_pend.size() > 0) && br;
    @(posedge clk);
    if (hs) void'(m_pend.pop_front());
    if (f) m_fill.delete();
    else if (v && rdy) begin
      if (m_fill.size() == 0) m_sc = s;
      m_fill.push_back(e);
      if (m_fill.size() == BS) begin
        nb.sc = m_sc;
        for (int i = 0; i < BS; i++) nb.el[i] = m_fill[i];
        m_pend.push_back(nb);
        m_fill.delete();
      end
    end
    m_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic fill(input int n, input logic [SW-1:0] sc0,
                      input logic [SW-1:0] sc_rest, input logic br);
    for (int i = 0; i < n; i++)
      step(1'b1, EW'($urandom), (i == 0) ? sc0 : sc_rest, 1'b0, br);
  endtask

  task automatic do_reset();
    elem_valid = 0; elem = 0; scale = 0; flush = 0; blk_ready = 0;
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    arr_t z;
    z = '0;
    elem_valid = 0; elem = 0; scale = 0; flush = 0; blk_ready = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    model_clear();
    @(negedge clk);
    checks++;
    if ({blk_valid, elem_ready, scale_nan} !== 3'b000) begin
      errs++;
      $display("FAIL reset_flags: got %b want 000",
               {blk_valid, elem_ready, scale_nan});
    end
    checks++;
    if (fill_count !== '0 || o_scale !== '0 || elements !== z) begin
      errs++;
      $display("FAIL reset_data: cnt=%0d scale=%h el=%h want 0",
               fill_count, o_scale, elements);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (elem_ready !== 1'b0) begin
      errs++;
      $display("FAIL reset_ready_early: got %b want 0", elem_ready);
    end
    @(negedge clk);
    step(1'b0, 0, 0, 1'b0, 1'b0);
    checks++;
    if (elem_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_ready_after: got %b want 1", elem_ready);
    end
  endtask

  task automatic test_basic();
    arr_t ex;
    do_reset();
    step(1'b0, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < BS; k++) begin
      ex[k] = EW'(k);
      if (k == 17) begin
        checks++;
        if (fill_count !== CW'(17)) begin
          errs++;
          $display("FAIL basic_count17: got %0d want 17", fill_count);
        end
      end
      if (k == BS - 1) begin
        checks++;
        if (blk_valid !== 1'b0) begin
          errs++;
          $display("FAIL basic_early_valid: got %b want 0", blk_valid);
        end
      end
      step(1'b1, EW'(k), (k == 0) ? 8'd127 : 8'($urandom), 1'b0, 1'b1);
    end
    checks++;
    if (blk_valid !== 1'b1 || fill_count !== '0) begin
      errs++;
      $display("FAIL basic_valid: valid=%b cnt=%0d want 1/0",
               blk_valid, fill_count);
    end
    checks++;
    if (elements !== ex || o_scale !== 8'd127 || scale_nan !== 1'b0) begin
      errs++;
      $display("FAIL basic_block: el=%h scale=%0d nan=%b want %h/127/0",
               elements, o_scale, scale_nan, ex);
    end
    step(1'b0, 0, 0, 1'b0, 1'b1);
    checks++;
    if (blk_valid !== 1'b0 || elem_ready !== 1'b1) begin
      errs++;
      $display("FAIL basic_consume: valid=%b ready=%b want 0/1",
               blk_valid, elem_ready);
    end
  endtask

  task automatic test_hold();
    blk_t    snap;
    logic [EW-1:0] e;
    do_reset();
    step(1'b0, 0, 0, 1'b0, 1'b0);
    fill(BS, 8'($urandom), 8'($urandom), 1'b0);
    snap = m_pend[0];
    for (int i = 0; i < 10; i++) begin
      e = EW'($urandom);
      elem_valid = 1'b1; elem = e; flush = 1'b0; blk_ready = 1'b0;
      #1;
      checks++;
      if (elem_ready !== exp_ready()) begin
        errs++;
        $display("FAIL hold_ready[%0d]: got %b want %b",
                 i, elem_ready, exp_ready());
      end
      checks++;
      if (blk_valid !== 1'b1 || elements !== snap.el ||
          o_scale !== snap.sc) begin
        errs++;
        $display("FAIL hold_stable[%0d]: v=%b sc=%h el=%h want 1/%h/%h",
                 i, blk_valid, o_scale, elements, snap.sc, snap.el);
      end
      step(1'b1, e, 8'($urandom), 1'b0, 1'b0);
    end
    checks++;
    if (fill_count !== CW'(m_fill.size())) begin
      errs++;
      $display("FAIL hold_count: got %0d want %0d",
               fill_count, m_fill.size());
    end
  endtask

  task automatic test_flush();
    blk_t snap;
    do_reset();
    step(1'b0, 0, 0, 1'b0, 1'b0);
    fill(5, 8'd9, 8'd9, 1'b0);
    checks++;
    if (fill_count !== CW'(5)) begin
      errs++;
      $display("FAIL flush_pre: got %0d want 5", fill_count);
    end
    elem_valid = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (elem_ready !== 1'b0) begin
      errs++;
      $display("FAIL flush_ready: got %b want 0", elem_ready);
    end
    step(1'b1, 8'h55, 8'd9, 1'b1, 1'b0);
    checks++;
    if (fill_count !== '0 || blk_valid !== 1'b0) begin
      errs++;
      $display("FAIL flush_clear: cnt=%0d v=%b want 0/0",
               fill_count, blk_valid);
    end
    fill(BS, 8'd3, 8'($urandom_range(4, 200)), 1'b0);
    checks++;
    if (blk_valid !== 1'b1 || o_scale !== 8'd3 ||
        elements !== m_pend[0].el) begin
      errs++;
      $display("FAIL flush_newblk: v=%b sc=%0d el=%h want 1/3/%h",
               blk_valid, o_scale, elements, m_pend[0].el);
    end
    step(1'b0, 0, 0, 1'b0, 1'b1);
    fill(BS - 1, 8'd1, 8'd1, 1'b0);
    step(1'b1, 8'h11, 8'd1, 1'b1, 1'b0);
    checks++;
    if (fill_count !== '0 || blk_valid !== 1'b0) begin
      errs++;
      $display("FAIL flush_last: cnt=%0d v=%b want 0/0",
               fill_count, blk_valid);
    end
    fill(BS, 8'd7, 8'd8, 1'b0);
    snap = m_pend[0];
    step(1'b0, 0, 0, 1'b1, 1'b0);
    checks++;
    if (blk_valid !== 1'b1 || elements !== snap.el || o_scale !== 8'd7) begin
      errs++;
      $display("FAIL flush_full: v=%b sc=%0d el=%h want 1/7/%h",
               blk_valid, o_scale, elements, snap.el);
    end
  endtask

  task automatic test_nan();
    do_reset();
    step(1'b0, 0, 0, 1'b0, 1'b0);
    fill(BS, 8'hFF, 8'($urandom_range(0, 254)), 1'b0);
    checks++;
    if (o_scale !== 8'hFF || scale_nan !== 1'b1) begin
      errs++;
      $display("FAIL nan_set: sc=%h nan=%b want ff/1", o_scale, scale_nan);
    end
    step(1'b0, 0, 0, 1'b0, 1'b1);
    checks++;
    if (scale_nan !== 1'b0) begin
      errs++;
      $display("FAIL nan_qual: got %b want 0", scale_nan);
    end
    fill(BS, 8'hFE, 8'hFF, 1'b0);
    checks++;
    if (o_scale !== 8'hFE || scale_nan !== 1'b0) begin
      errs++;
      $display("FAIL nan_clear: sc=%h nan=%b want fe/0", o_scale, scale_nan);
    end
  endtask

  task automatic test_reset_mid();
    arr_t z;
    z = '0;
    do_reset();
    step(1'b0, 0, 0, 1'b0, 1'b0);
    fill(17, 8'd5, 8'd6, 1'b0);
    checks++;
    if (fill_count !== CW'(17)) begin
      errs++;
      $display("FAIL rstmid_pre: got %0d want 17", fill_count);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (blk_valid !== 1'b0 || fill_count !== '0 || elem_ready !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_fill: v=%b cnt=%0d rdy=%b want 0/0/0",
               blk_valid, fill_count, elem_ready);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 0, 0, 1'b0, 1'b0);
    fill(BS, 8'd42, 8'd1, 1'b0);
    checks++;
    if (blk_valid !== 1'b1 || o_scale !== 8'd42 ||
        elements !== m_pend[0].el) begin
      errs++;
      $display("FAIL rstmid_next: v=%b sc=%0d el=%h want 1/42/%h",
               blk_valid, o_scale, elements, m_pend[0].el);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (blk_valid !== 1'b0 || o_scale !== '0 || elements !== z) begin
      errs++;
      $display("FAIL rstmid_full: v=%b sc=%h el=%h want 0",
               blk_valid, o_scale, elements);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 0, 0, 1'b0, 1'b0);
    fill(BS, 8'd77, 8'd2, 1'b1);
    checks++;
    if (blk_valid !== 1'b1 || o_scale !== 8'd77 ||
        elements !== m_pend[0].el) begin
      errs++;
      $display("FAIL rstmid_after: v=%b sc=%0d el=%h want 1/77/%h",
               blk_valid, o_scale, elements, m_pend[0].el);
    end
  endtask

  task automatic test_back_to_back();
    int hs;
    int hs_cyc[3];
    logic [EW-1:0] e;
    logic [SW-1:0] s;
    hs = 0;
    do_reset();
    step(1'b0, 0, 0, 1'b0, 1'b0);
    for (int c = 0; c < 200 && hs < 3; c++) begin
      e = EW'($urandom);
      s = SW'($urandom);
      elem_valid = 1'b1; elem = e; scale = s; flush = 1'b0; blk_ready = 1'b1;
      #1;
      checks++;
      if (elem_ready !== exp_ready() || blk_valid !== (m_pend.size() > 0)) begin
        errs++;
        $display("FAIL b2b_flow[%0d]: rdy=%b v=%b want %b/%b", c,
                 elem_ready, blk_valid, exp_ready(), m_pend.size() > 0);
      end
      if (m_pend.size() > 0) begin
        checks++;
        if (elements !== m_pend[0].el || o_scale !== m_pend[0].sc) begin
          errs++;
          $display("FAIL b2b_block%0d: sc=%h el=%h want %h/%h", hs,
                   o_scale, elements, m_pend[0].sc, m_pend[0].el);
        end
        hs_cyc[hs] = c;
        hs++;
      end
      step(1'b1, e, s, 1'b0, 1'b1);
    end
    checks++;
    if (hs < 3) begin
      errs++;
      $display("FAIL b2b_timeout: got %0d blocks want 3", hs);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (hs_cyc[i] - hs_cyc[i-1] != SPACING) begin
          errs++;
          $display("FAIL b2b_spacing%0d: got %0d want %0d", i,
                   hs_cyc[i] - hs_cyc[i-1], SPACING);
        end
      end
    end
  endtask

  task automatic test_random();
    logic v, f, br;
    logic [EW-1:0] e;
    logic [SW-1:0] s;
    do_reset();
    for (int c = 0; c < 700; c++) begin
      v  = ($urandom_range(0, 9) < 7);
      br = ($urandom_range(0, 9) < 4);
      f  = ($urandom_range(0, 99) < 2);
      e  = EW'($urandom);
      s  = ($urandom_range(0, 7) == 0) ? 8'hFF : SW'($urandom);
      elem_valid = v; elem = e; scale = s; flush = f; blk_ready = br;
      #1;
      checks++;
      if (elem_ready !== exp_ready() || blk_valid !== (m_pend.size() > 0) ||
          fill_count !== CW'(m_fill.size())) begin
        errs++;
        $display("FAIL rand_ctl[%0d]: rdy=%b v=%b cnt=%0d want %b/%b/%0d",
                 c, elem_ready, blk_valid, fill_count, exp_ready(),
                 m_pend.size() > 0, m_fill.size());
      end
      if (m_pend.size() > 0) begin
        checks++;
        if (elements !== m_pend[0].el || o_scale !== m_pend[0].sc ||
            scale_nan !== (m_pend[0].sc == 8'hFF)) begin
          errs++;
          $display("FAIL rand_blk[%0d]: sc=%h nan=%b el=%h want %h/%h",
                   c, o_scale, scale_nan, elements,
                   m_pend[0].sc, m_pend[0].el);
        end
      end
      step(v, e, s, f, br);
    end
  endtask

  initial begin
    errs = 0;
    checks = 0;
    rst = 1'b1;
    elem_valid = 0; elem = 0; scale = 0; flush = 0; blk_ready = 0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_basic();
    test_hold();
    test_flush();
    test_nan();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
